// File: rtl/ball_game_pkg.sv
// Shared constants, state encoding and ball-size lookup for the ball game controller.
package ball_game_pkg;

  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned SPEED_INIT   = 2;
  localparam int unsigned SPEED_MAX    = 8;
  localparam int unsigned VY_SPEED     = 2;
  localparam int unsigned SERVE_FRAMES = 60;
  localparam int unsigned HIT_THRESH   = 16;
  localparam int unsigned SCORE_MAX    = 99;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned CALC_W  = 12;
  localparam int unsigned VEL_W   = 5;
  localparam int unsigned HIT_W   = 10;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned SERVE_W = 6;
  localparam int unsigned LFSR_W  = 8;

  localparam logic [POS_W-1:0]  CENTER_X  = POS_W'(310);
  localparam logic [POS_W-1:0]  CENTER_Y  = POS_W'(230);
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

  function automatic logic [6:0] ball_size(input logic [1:0] sel);
    case (sel)
      2'd0:    return 7'd20;
      2'd1:    return 7'd40;
      default: return 7'd64;
    endcase
  endfunction

endpackage

// File: rtl/ball_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1); exposes the low bits used for serve randomness.
module ball_lfsr
  import ball_game_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [2:0]        rnd
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= seed;
    else       lfsr_q <= lfsr_d;
  end

  assign rnd = lfsr_q[2:0];

endmodule

// File: rtl/ball_game_ctrl.sv
// Per-frame game/physics controller: serve timing, ball motion, paddle hits, score and game-over.
module ball_game_ctrl
  import ball_game_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [POS_W-1:0]   x_pixel,
  input  logic [POS_W-1:0]   y_pixel,
  input  logic               is_hit_area,
  input  logic               color_Diff,
  input  logic               btn_start,
  output logic [POS_W-1:0]   ball_x,
  output logic [POS_W-1:0]   ball_y,
  output logic [1:0]         rand_ball,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               is_idle
);

  localparam logic [VEL_W-1:0] VX_INIT = VEL_W'(SPEED_INIT);
  localparam logic [VEL_W-1:0] VX_MAX  = VEL_W'(SPEED_MAX);
  localparam logic [VEL_W-1:0] VY_POS  = VEL_W'(VY_SPEED);
  localparam logic [VEL_W-1:0] VY_NEG  = VEL_W'(0) - VY_POS;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   x_q, x_d, y_q, y_d;
  logic [VEL_W-1:0]   vx_q, vx_d, vy_q, vy_d;
  logic [1:0]         size_q, size_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SERVE_W-1:0] serve_q, serve_d;
  logic [HIT_W-1:0]   hit_q, hit_d;
  logic               game_over_q, game_over_d;
  logic               is_idle_q, is_idle_d;

  logic [2:0]         rnd;
  logic               frame_tick, hit_px, frame_hit;
  logic [CALC_W-1:0]  size_px, nx, ny;
  logic [VEL_W-1:0]   vx_abs, vx_inc;

  ball_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .seed  (LFSR_SEED),
    .rnd   (rnd)
  );

  assign frame_tick = (x_pixel == '0) && (y_pixel == POS_W'(V_ACTIVE));
  assign hit_px     = is_hit_area && color_Diff && (y_pixel < POS_W'(V_ACTIVE));

  // Velocities are 5-bit two's complement; positions are evaluated in 12 bits so overshoot is visible.
  assign size_px   = CALC_W'(ball_size(size_q));
  assign nx        = CALC_W'(x_q) + {{(CALC_W-VEL_W){vx_q[VEL_W-1]}}, vx_q};
  assign ny        = CALC_W'(y_q) + {{(CALC_W-VEL_W){vy_q[VEL_W-1]}}, vy_q};
  assign vx_abs    = vx_q[VEL_W-1] ? (~vx_q + VEL_W'(1)) : vx_q;
  assign vx_inc    = (vx_abs >= VX_MAX) ? VX_MAX : (vx_abs + VEL_W'(1));
  assign frame_hit = (hit_q >= HIT_W'(HIT_THRESH)) && !vx_q[VEL_W-1] && (vx_q != '0);

  // Overlap counter: saturates, sampled and cleared on frame_tick.
  always_comb begin
    hit_d = hit_q;
    if (frame_tick)                hit_d = '0;
    else if (hit_px && hit_q != '1) hit_d = hit_q + HIT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    size_d  = size_q;
    score_d = score_q;
    serve_d = serve_q;
    case (state_q)
      IDLE: begin
        x_d = CENTER_X;
        y_d = CENTER_Y;
        if (btn_start) begin
          state_d = SERVE;
          size_d  = (rnd[1:0] == 2'd3) ? 2'd2 : rnd[1:0];
          vy_d    = rnd[2] ? VY_NEG : VY_POS;
          serve_d = '0;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (serve_q == SERVE_W'(SERVE_FRAMES - 1)) begin
            state_d = PLAY;
            vx_d    = VX_INIT;
            serve_d = '0;
          end else begin
            serve_d = serve_q + SERVE_W'(1);
          end
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (ny[CALC_W-1] || ny == '0) begin
            y_d  = '0;
            vy_d = VY_POS;
          end else if (ny + size_px >= CALC_W'(V_ACTIVE)) begin
            y_d  = POS_W'(CALC_W'(V_ACTIVE) - size_px);
            vy_d = VY_NEG;
          end else begin
            y_d = POS_W'(ny);
          end
          // A hit takes priority over a right-edge miss in the same frame.
          if (frame_hit) begin
            vx_d = ~vx_inc + VEL_W'(1);
            if (score_q != SCORE_W'(SCORE_MAX)) score_d = score_q + SCORE_W'(1);
          end else if (nx[CALC_W-1] || nx == '0) begin
            x_d  = '0;
            vx_d = vx_abs;
          end else if (nx + size_px > CALC_W'(H_ACTIVE)) begin
            x_d     = POS_W'(CALC_W'(H_ACTIVE) - size_px);
            state_d = OVER;
          end else begin
            x_d = POS_W'(nx);
          end
        end
      end
      OVER: begin
        if (btn_start) begin
          state_d = IDLE;
          score_d = '0;
          x_d     = CENTER_X;
          y_d     = CENTER_Y;
        end
      end
      default: state_d = IDLE;
    endcase
    game_over_d = (state_d == OVER);
    is_idle_d   = (state_d == IDLE) || (state_d == SERVE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= CENTER_X;
      y_q         <= CENTER_Y;
      vx_q        <= '0;
      vy_q        <= VY_POS;
      size_q      <= '0;
      score_q     <= '0;
      serve_q     <= '0;
      hit_q       <= '0;
      game_over_q <= 1'b0;
      is_idle_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      size_q      <= size_d;
      score_q     <= score_d;
      serve_q     <= serve_d;
      hit_q       <= hit_d;
      game_over_q <= game_over_d;
      is_idle_q   <= is_idle_d;
    end
  end

  assign ball_x    = x_q;
  assign ball_y    = y_q;
  assign rand_ball = size_q;
  assign score     = score_q;
  assign game_over = game_over_q;
  assign is_idle   = is_idle_q;

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Randomized bench for ball_game_ctrl: a frame-level game model feeds an expectation queue drained by a monitor.
module tb_ball_game_ctrl;

  localparam int H = 640;
  localparam int V = 480;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x_pixel, y_pixel;
  logic       is_hit_area, color_Diff, btn_start;
  logic [9:0] ball_x, ball_y;
  logic [1:0] rand_ball;
  logic [7:0] score;
  logic       game_over, is_idle;

  always #5 clk = ~clk;

  ball_game_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .x_pixel     (x_pixel),
    .y_pixel     (y_pixel),
    .is_hit_area (is_hit_area),
    .color_Diff  (color_Diff),
    .btn_start   (btn_start),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .rand_ball   (rand_ball),
    .score       (score),
    .game_over   (game_over),
    .is_idle     (is_idle)
  );

  typedef struct {
    int bx; int by; int rb; int sc; int go; int idle;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Game model: 0=idle 1=serve 2=play 3=over
  int   m_st, m_x, m_y, m_vx, m_vy, m_sel, m_score, m_serve, m_pix;
  logic [7:0] m_lfsr;

  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input int sel);
    return (sel == 0) ? 20 : (sel == 1) ? 40 : 64;
  endfunction

  task automatic model_reset();
    m_st = 0; m_x = 310; m_y = 230; m_vx = 0; m_vy = 2;
    m_sel = 0; m_score = 0; m_serve = 0; m_pix = 0;
  endtask

  task automatic model_btn();
    if (m_st == 0) begin
      m_st    = 1;
      m_sel   = (m_lfsr[1:0] == 2'd3) ? 2 : int'(m_lfsr[1:0]);
      m_vy    = m_lfsr[2] ? -2 : 2;
      m_serve = 0;
    end else if (m_st == 3) begin
      m_st = 0; m_score = 0; m_x = 310; m_y = 230;
    end
  endtask

  task automatic model_tick(input int npix);
    int s, nx, ny, mag, cnt;
    bit hit;
    cnt = (npix > 1023) ? 1023 : npix;
    if (m_st == 1) begin
      if (m_serve == 59) begin m_st = 2; m_vx = 2; m_serve = 0; end
      else m_serve++;
    end else if (m_st == 2) begin
      s   = size_of(m_sel);
      nx  = m_x + m_vx;
      ny  = m_y + m_vy;
      mag = (m_vx < 0) ? -m_vx : m_vx;
      hit = (cnt >= 16) && (m_vx > 0);
      if (ny <= 0)          begin m_y = 0;     m_vy = 2;  end
      else if (ny + s >= V) begin m_y = V - s; m_vy = -2; end
      else                  m_y = ny;
      if (hit) begin
        m_vx    = -((mag + 1 > 8) ? 8 : mag + 1);
        m_score = (m_score < 99) ? m_score + 1 : 99;
      end else if (nx <= 0) begin
        m_x = 0; m_vx = mag;
      end else if (nx + s > H) begin
        m_x = H - s; m_st = 3;
      end else begin
        m_x = nx;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.bx = m_x; e.by = m_y; e.rb = m_sel; e.sc = m_score;
    e.go = (m_st == 3) ? 1 : 0;
    e.idle = (m_st <= 1) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; any frame_tick or button press queues the model's expected outputs.
  task automatic cycle(input int x, input int y, input bit ha, input bit cd, input bit btn);
    x_pixel = 10'(x); y_pixel = 10'(y);
    is_hit_area = ha; color_Diff = cd; btn_start = btn;
    if (ha && cd && y < V) m_pix++;
    if (btn) begin
      model_btn(); push_exp();
    end else if (x == 0 && y == V) begin
      model_tick(m_pix); m_pix = 0; push_exp();
    end
    @(posedge clk); #1;
  endtask

  task automatic frame(input int hits, input bit noise);
    for (int i = 0; i < hits; i++) cycle(100 + i, 200, 1'b1, 1'b1, 1'b0);
    if (noise) begin
      cycle(50, 10, 1'b1, 1'b0, 1'b0);
      cycle(51, 10, 1'b0, 1'b1, 1'b0);
      cycle(3, V, 1'b1, 1'b1, 1'b0);
      cycle(4, V + 5, 1'b1, 1'b1, 1'b0);
    end
    cycle(0, V, 1'b0, 1'b0, 1'b0);
    cycle(7, V + 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ball_x"},    int'(ball_x),    310);
    chk({tag, "_ball_y"},    int'(ball_y),    230);
    chk({tag, "_rand_ball"}, int'(rand_ball), 0);
    chk({tag, "_score"},     int'(score),     0);
    chk({tag, "_game_over"}, int'(game_over), 0);
    chk({tag, "_is_idle"},   int'(is_idle),   1);
  endtask

  task automatic do_reset();
    #3;
    reset = 1'b1;
    exp_q.delete();
    model_reset();
    @(posedge clk); #1;
    chk_reset_vals("midplay_rst");
    reset = 1'b0;
  endtask

  // mode 0: random hits, 1: hit every frame (score/speed saturation), 2: reset mid-play
  task automatic play_game(input int mode);
    int hits, cap;
    cap = (mode == 1) ? 500 : 300;
    cycle(9, V + 2, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 60; f++) frame(0, (f % 2) == 1);
    for (int f = 0; f < cap && m_st == 2; f++) begin
      if (mode == 2 && f == 30) begin
        do_reset();
        return;
      end
      if (mode == 0 && f == 10) cycle(9, V + 2, 1'b0, 1'b0, 1'b1);
      if (mode == 1) hits = 20;
      else begin
        case ($urandom_range(0, 7))
          4:       hits = 15;
          5:       hits = 16;
          6:       hits = 20;
          7:       hits = 17;
          default: hits = 0;
        endcase
      end
      frame(hits, 1'($urandom_range(0, 1)));
    end
    for (int f = 0; f < 800 && m_st == 2; f++) frame(0, 1'b0);
    frame(0, 1'b1);
    frame(0, 1'b0);
    cycle(9, V + 2, 1'b0, 1'b0, 1'b1);
    frame(0, 1'b0);
  endtask

  // Monitor: outputs change only after a frame_tick or button press; compare one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!reset && (btn_start || (x_pixel == 10'd0 && y_pixel == 10'(V)))) begin
        #2;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL scoreboard_empty: got no expectation at t=%0t, required one", $time);
        end else begin
          e = exp_q.pop_front();
          chk("ball_x",    int'(ball_x),    e.bx);
          chk("ball_y",    int'(ball_y),    e.by);
          chk("rand_ball", int'(rand_ball), e.rb);
          chk("score",     int'(score),     e.sc);
          chk("game_over", int'(game_over), e.go);
          chk("is_idle",   int'(is_idle),   e.idle);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    x_pixel = 10'd5; y_pixel = 10'd0;
    is_hit_area = 1'b0; color_Diff = 1'b0; btn_start = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_reset_vals("por");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) frame(0, 1'b1);
    play_game(0);
    play_game(1);
    play_game(2);
    play_game(0);
    play_game(0);
    repeat (3) begin @(posedge clk); #1; end
    chk("queue_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
